pulse_period_meter: RTL and testbench
=====================================

Name: pulse_period_meter

Overview:
Downstream consumer of the single-cycle rising-edge pulse produced by the edge-detect stage. Measures the number of clk cycles between consecutive pulses and counts pulses. Presents each period result on a valid/ready output port for a register interface or logging FIFO. Flags counter saturation and results dropped under back-pressure.

Parameters:
CNT_W, 16, width of the period counter and of period_out
PCNT_W, 16, width of the free-running pulse counter

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  measurement enable; low forces IDLE
pulse_in  input  1  one-cycle pulse from edge detector (already synchronous to clk)
period_out  output  CNT_W  measured period in clk cycles
period_ovf  output  1  qualifies period_out: counter saturated during this period
period_valid  output  1  result held on period_out/period_ovf
period_ready  input  1  consumer accepts result when valid && ready
pulse_count  output  PCNT_W  pulses seen while enable=1, wraps modulo 2^PCNT_W
drop_sticky  output  1  a completed result was discarded; cleared only by reset
busy  output  1  high in WAIT_FIRST or MEASURE

Behaviour:
- Reset (reset=1 at clk edge): state=IDLE; cnt=0; period_out=0; period_ovf=0; period_valid=0; pulse_count=0; drop_sticky=0; busy=0. Reset overrides every other input, including mid-measurement and a pending valid result.
- States:
  - IDLE: enable=0 -> stay. enable=1 -> WAIT_FIRST; a pulse in that same cycle is ignored.
  - WAIT_FIRST: pulse_in=1 -> MEASURE, cnt<=1, pulse_count+1. Produces no result (no reference edge yet).
  - MEASURE, pulse_in=0: cnt<=cnt+1, saturating at 2^CNT_W-1; ovf_flag<=1 when saturation reached.
  - MEASURE, pulse_in=1: completes a result (period=cnt, ovf=ovf_flag); cnt<=1; ovf_flag<=0; pulse_count+1; stay MEASURE.
  - Any state, enable=0 (and not reset) -> IDLE next cycle; cnt and ovf_flag cleared; a pulse in that cycle is ignored and not counted.
- Period definition: pulses at cycles t0 and t1 give period_out = t1-t0. Consecutive-cycle pulses give 1. Minimum reportable period is 1.
- Output register, latency 1: result completed at edge N is visible with period_valid=1 after edge N.
  - period_valid=1 holds period_out/period_ovf stable until period_valid && period_ready.
  - Accept with no new result: period_valid<=0. period_out keeps its last value.
  - New result, period_valid=0: load it.
  - New result, valid && ready in the same cycle: load new result; period_valid stays 1.
  - New result, valid && !ready: discard new result; drop_sticky<=1; held result unchanged.
- enable=0 does not clear a pending result; it remains deliverable.
- pulse_count increments only on pulses taken in WAIT_FIRST or MEASURE, and wraps 2^PCNT_W-1 -> 0.
- busy = (state != IDLE), registered with state.

Test Plan:
- Reset, enable=1, ready=1, pulses at cycles 10, 20, 25 -> no result after 10; results 10 then 5, each period_valid for exactly one cycle, one cycle after cycles 20 and 25; pulse_count=3; period_ovf=0.
- CNT_W=4, pulses 20 cycles apart -> period_out=15, period_ovf=1. Next pair 3 apart -> period_out=3, period_ovf=0.
- ready=0, pulses at 0, 4, 9 -> period_out=4 held; second result dropped; drop_sticky=1. Raise ready -> one accept, then period_valid=0.
- Pulses at 0, 4, 7 with ready pulsed high on the cycle the second result completes -> 4 accepted and 3 loaded back-to-back; drop_sticky stays 0.
- enable dropped for 5 cycles mid-MEASURE with a pulse inside the low window -> that pulse ignored and not counted; after re-enable, the first pulse yields no result and the second yields the correct period.
- reset asserted while period_valid=1 and state=MEASURE -> all outputs 0 next cycle; subsequent pulses behave as after power-up.

Source files
------------

// File: rtl/pulse_period_meter_if.sv
// Bundle between the period meter and its consumer: pulse/enable inputs,
// the valid/ready result port and status outputs.
interface pulse_period_meter_if #(
  parameter int CNT_W  = 16,
  parameter int PCNT_W = 16
);
  logic              enable;
  logic              pulse_in;
  logic [CNT_W-1:0]  period_out;
  logic              period_ovf;
  logic              period_valid;
  logic              period_ready;
  logic [PCNT_W-1:0] pulse_count;
  logic              drop_sticky;
  logic              busy;

  modport master (
    output enable, pulse_in, period_ready,
    input  period_out, period_ovf, period_valid, pulse_count, drop_sticky, busy
  );

  modport slave (
    input  enable, pulse_in, period_ready,
    output period_out, period_ovf, period_valid, pulse_count, drop_sticky, busy
  );
endinterface

// File: rtl/pulse_period_meter.sv
// Measures clk cycles between consecutive edge-detector pulses, counts pulses,
// and holds each period in a one-deep valid/ready output register.
module pulse_period_meter #(
  parameter int CNT_W  = 16,
  parameter int PCNT_W = 16
) (
  input  logic clk,
  input  logic reset,
  pulse_period_meter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    MEASURE    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state;
  logic              busy_r;
  logic [CNT_W-1:0]  cnt_p0;
  logic              ovf_p0;
  logic [PCNT_W-1:0] pcnt;

  logic [CNT_W-1:0]  period_p1;
  logic              ovf_p1;
  logic              vld_p1;
  logic              drop_r;

  logic take;
  logic done;
  logic accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  assign take   = bus.enable && bus.pulse_in && (state != IDLE);
  assign done   = take && (state == MEASURE);
  assign accept = vld_p1 && bus.period_ready;

  // Stage p0: measurement FSM, period counter, pulse counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy_r <= 1'b0;
      cnt_p0 <= '0;
      ovf_p0 <= 1'b0;
      pcnt   <= '0;
    end else begin
      if (take) pcnt <= pcnt + 1'b1;
      if (!bus.enable) begin
        state  <= IDLE;
        busy_r <= 1'b0;
        cnt_p0 <= '0;
        ovf_p0 <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state  <= WAIT_FIRST;
            busy_r <= 1'b1;
          end
          WAIT_FIRST: begin
            if (bus.pulse_in) begin
              state  <= MEASURE;
              cnt_p0 <= CNT_W'(1);
            end
          end
          MEASURE: begin
            if (bus.pulse_in) begin
              cnt_p0 <= CNT_W'(1);
              ovf_p0 <= 1'b0;
            end else begin
              // Flag only once a cycle is actually lost, so a period of exactly CNT_MAX is exact.
              if (cnt_p0 == CNT_MAX) ovf_p0 <= 1'b1;
              cnt_p0 <= sat_inc(cnt_p0);
            end
          end
          default: begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end
        endcase
      end
    end
  end

  // Stage p1: one-deep result register with back-pressure drop detection
  always_ff @(posedge clk) begin
    if (reset) begin
      period_p1 <= '0;
      ovf_p1    <= 1'b0;
      vld_p1    <= 1'b0;
      drop_r    <= 1'b0;
    end else if (done) begin
      if (!vld_p1 || bus.period_ready) begin
        period_p1 <= cnt_p0;
        ovf_p1    <= ovf_p0;
        vld_p1    <= 1'b1;
      end else begin
        drop_r <= 1'b1;
      end
    end else if (accept) begin
      vld_p1 <= 1'b0;
    end
  end

  assign bus.period_out   = period_p1;
  assign bus.period_ovf   = ovf_p1;
  assign bus.period_valid = vld_p1;
  assign bus.pulse_count  = pcnt;
  assign bus.drop_sticky  = drop_r;
  assign bus.busy         = busy_r;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Bench for pulse_period_meter: vector table, directed corner sequences and
// randomized traffic against a timestamp-based reference model.
module tb_pulse_period_meter;

  localparam int CNT_W  = 4;
  localparam int PCNT_W = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;
  localparam int PMOD   = 1 << PCNT_W;

  logic clk = 1'b0;
  logic reset;

  pulse_period_meter_if #(.CNT_W(CNT_W), .PCNT_W(PCNT_W)) ifc ();

  pulse_period_meter #(.CNT_W(CNT_W), .PCNT_W(PCNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: pulse timestamps, period = difference of timestamps
  int m_cyc, m_tref, m_per, m_count;
  bit m_active, m_have_ref, m_valid, m_ovf, m_drop;

  typedef struct {
    int en; int p; int rd;
    int ev; int eper; int edrop; int ebusy; int ecnt;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_update(input bit r, input bit e, input bit p, input bit rd);
    bit new_res;
    int d;
    new_res = 1'b0;
    d = 0;
    m_cyc++;
    if (r) begin
      m_active = 0; m_have_ref = 0; m_valid = 0; m_per = 0;
      m_ovf = 0; m_drop = 0; m_count = 0;
      return;
    end
    if (!e) begin
      m_active = 0;
      m_have_ref = 0;
    end else if (!m_active) begin
      m_active = 1;
    end else if (p) begin
      m_count = (m_count + 1) % PMOD;
      if (m_have_ref) begin
        new_res = 1'b1;
        d = m_cyc - m_tref;
      end
      m_have_ref = 1;
      m_tref = m_cyc;
    end
    if (new_res) begin
      if (!m_valid || rd) begin
        m_valid = 1;
        m_per = (d > CMAX) ? CMAX : d;
        m_ovf = (d > CMAX);
      end else begin
        m_drop = 1;
      end
    end else if (m_valid && rd) begin
      m_valid = 0;
    end
  endtask

  task automatic step(input bit r, input bit e, input bit p, input bit rd);
    reset = r;
    ifc.enable = e;
    ifc.pulse_in = p;
    ifc.period_ready = rd;
    @(posedge clk);
    model_update(r, e, p, rd);
    #1;
    chk("model_valid", ifc.period_valid, m_valid);
    chk("model_period", ifc.period_out, m_per);
    chk("model_ovf", ifc.period_ovf, m_ovf);
    chk("model_count", ifc.pulse_count, m_count);
    chk("model_drop", ifc.drop_sticky, m_drop);
    chk("model_busy", ifc.busy, m_active);
  endtask

  initial begin
    m_cyc = 0; m_tref = 0; m_per = 0; m_count = 0;
    m_active = 0; m_have_ref = 0; m_valid = 0; m_ovf = 0; m_drop = 0;
    reset = 1'b1;
    ifc.enable = 1'b0;
    ifc.pulse_in = 1'b0;
    ifc.period_ready = 1'b0;

    // Reset state
    step(1, 0, 0, 0);
    chk("rst_valid", ifc.period_valid, 0);
    chk("rst_period", ifc.period_out, 0);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_count", ifc.pulse_count, 0);

    // Table: ready held low, pulses at 0/4/9, then one accept
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 1, 0};
    tbl[1]  = '{1, 1, 0, 0, 0, 0, 1, 1};
    tbl[2]  = '{1, 0, 0, 0, 0, 0, 1, 1};
    tbl[3]  = '{1, 0, 0, 0, 0, 0, 1, 1};
    tbl[4]  = '{1, 0, 0, 0, 0, 0, 1, 1};
    tbl[5]  = '{1, 1, 0, 1, 4, 0, 1, 2};
    tbl[6]  = '{1, 0, 0, 1, 4, 0, 1, 2};
    tbl[7]  = '{1, 0, 0, 1, 4, 0, 1, 2};
    tbl[8]  = '{1, 0, 0, 1, 4, 0, 1, 2};
    tbl[9]  = '{1, 0, 0, 1, 4, 0, 1, 2};
    tbl[10] = '{1, 1, 0, 1, 4, 1, 1, 3};
    tbl[11] = '{1, 0, 1, 0, 4, 1, 1, 3};
    tbl[12] = '{1, 0, 0, 0, 4, 1, 1, 3};
    for (int i = 0; i < 13; i++) begin
      step(0, tbl[i].en != 0, tbl[i].p != 0, tbl[i].rd != 0);
      chk($sformatf("tbl%0d_valid", i), ifc.period_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_period", i), ifc.period_out, tbl[i].eper);
      chk($sformatf("tbl%0d_drop", i), ifc.drop_sticky, tbl[i].edrop);
      chk($sformatf("tbl%0d_busy", i), ifc.busy, tbl[i].ebusy);
      chk($sformatf("tbl%0d_count", i), ifc.pulse_count, tbl[i].ecnt);
    end

    // Pulses at 10, 20, 25 with ready high
    step(1, 0, 0, 1);
    for (int c = 0; c <= 30; c++) begin
      step(0, 1, (c == 10 || c == 20 || c == 25), 1);
      chk($sformatf("basic_valid_c%0d", c), ifc.period_valid, (c == 20 || c == 25));
      if (c == 20) chk("basic_period10", ifc.period_out, 10);
      if (c == 25) chk("basic_period5", ifc.period_out, 5);
    end
    chk("basic_count", ifc.pulse_count, 3);
    chk("basic_ovf", ifc.period_ovf, 0);

    // Saturation: 20 apart, then 3 apart
    step(1, 0, 0, 1);
    step(0, 1, 0, 1);
    step(0, 1, 1, 1);
    for (int i = 0; i < 19; i++) step(0, 1, 0, 1);
    step(0, 1, 1, 1);
    chk("sat_valid", ifc.period_valid, 1);
    chk("sat_period", ifc.period_out, 15);
    chk("sat_ovf", ifc.period_ovf, 1);
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    step(0, 1, 1, 1);
    chk("sat_next_period", ifc.period_out, 3);
    chk("sat_next_ovf", ifc.period_ovf, 0);

    // Back-to-back accept and load: pulses 0/4/7, ready only at 7
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    chk("b2b_first", ifc.period_out, 4);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 1);
    chk("b2b_valid", ifc.period_valid, 1);
    chk("b2b_period", ifc.period_out, 3);
    chk("b2b_drop", ifc.drop_sticky, 0);
    step(0, 1, 0, 1);
    chk("b2b_drained", ifc.period_valid, 0);

    // Enable low window with an ignored pulse
    step(1, 0, 0, 1);
    step(0, 1, 0, 1);
    step(0, 1, 1, 1);
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, (i == 2), 1);
    chk("en_busy_low", ifc.busy, 0);
    chk("en_count_kept", ifc.pulse_count, 1);
    step(0, 1, 0, 1);
    chk("en_busy_back", ifc.busy, 1);
    step(0, 1, 1, 1);
    chk("en_first_no_result", ifc.period_valid, 0);
    chk("en_count2", ifc.pulse_count, 2);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 1);
    step(0, 1, 1, 1);
    chk("en_second_valid", ifc.period_valid, 1);
    chk("en_second_period", ifc.period_out, 6);
    chk("en_count3", ifc.pulse_count, 3);

    // Reset while a result is pending and measuring
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    chk("mid_valid", ifc.period_valid, 1);
    chk("mid_period", ifc.period_out, 3);
    step(1, 1, 1, 0);
    chk("mid_rst_valid", ifc.period_valid, 0);
    chk("mid_rst_period", ifc.period_out, 0);
    chk("mid_rst_ovf", ifc.period_ovf, 0);
    chk("mid_rst_count", ifc.pulse_count, 0);
    chk("mid_rst_drop", ifc.drop_sticky, 0);
    chk("mid_rst_busy", ifc.busy, 0);
    step(0, 1, 0, 1);
    step(0, 1, 1, 1);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 1);
    step(0, 1, 1, 1);
    chk("post_rst_period", ifc.period_out, 7);
    chk("post_rst_count", ifc.pulse_count, 2);

    // Randomized traffic with varying pulse density
    for (int blk = 0; blk < 15; blk++) begin
      int rate;
      rate = (blk % 3 == 0) ? 1 : ((blk % 3 == 1) ? 7 : 31);
      for (int i = 0; i < 200; i++) begin
        step($urandom_range(0, 499) == 0,
             $urandom_range(0, 15) != 0,
             $urandom_range(0, rate) == 0,
             $urandom_range(0, 1) == 1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
